// File: rtl/mult_share_ctrl_if.sv
// rtl/mult_share_ctrl_if.sv - request/response and shared-multiplier signal bundle for mult_share_ctrl
interface mult_share_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic                 rsp0_valid;
    logic                 rsp0_ready;
    logic                 rsp1_valid;
    logic                 rsp1_ready;
    logic [2*WIDTH-1:0]   rsp_p;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic [2*WIDTH-1:0]   mul_y;
    logic                 busy;

    // Requesters and the multiplier array side of the controller
    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, mul_y,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_p,
        input  mul_a, mul_b, busy
    );

    // The controller itself
    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, mul_y,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_p,
        output mul_a, mul_b, busy
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - two-requester arbiter sharing one multiplier; MULT_SHARE_RR_EN selects round-robin
module mult_share_ctrl #(
    parameter int WIDTH    = 4,
    parameter int MUL_WAIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    mult_share_ctrl_if.slave   ms
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Capture happens on the BUSY edge where the counter reaches this value
    localparam logic [3:0] CNT_LAST = 4'(MUL_WAIT - 1);

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           cnt;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 gnt;
    logic [2*WIDTH-1:0]   prod;
    logic                 gnt_sel;
    logic                 accept;
    logic                 any_valid;
    logic                 rsp_taken;

    assign any_valid = ms.req0_valid | ms.req1_valid;
    assign rsp_taken = gnt ? ms.rsp1_ready : ms.rsp0_ready;

`ifdef MULT_SHARE_RR_EN
    logic last_gnt;

    // Round-robin: on a tie the requester that did not win last time is granted
    always_comb begin
        gnt_sel = 1'b0;
        if (!ms.req0_valid) begin
            gnt_sel = 1'b1;
        end else if (ms.req1_valid) begin
            gnt_sel = !last_gnt;
        end
    end

    // Remember the winner of each accept; reset value lets requester 0 win first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (accept) begin
            last_gnt <= gnt_sel;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid
    always_comb begin
        gnt_sel = !ms.req0_valid;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, grant handshake and response valids
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        ms.req0_ready = 1'b0;
        ms.req1_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    accept        = 1'b1;
                    ms.req0_ready = !gnt_sel;
                    ms.req1_ready = gnt_sel;
                    state_nxt     = BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_taken) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch, grant record, settle counter and product capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
            gnt  <= 1'b0;
            cnt  <= '0;
            prod <= '0;
        end else if (accept) begin
            op_a <= gnt_sel ? ms.req1_a : ms.req0_a;
            op_b <= gnt_sel ? ms.req1_b : ms.req0_b;
            gnt  <= gnt_sel;
            cnt  <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt + 4'd1;
            if (cnt == CNT_LAST) begin
                prod <= ms.mul_y;
            end
        end
    end

    // Operands stay on the multiplier between transactions; product is held until handshake
    always_comb begin
        ms.mul_a      = op_a;
        ms.mul_b      = op_b;
        ms.rsp_p      = prod;
        ms.rsp0_valid = (state == RESP) && !gnt;
        ms.rsp1_valid = (state == RESP) && gnt;
        ms.busy       = (state != IDLE);
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - self-checking bench for mult_share_ctrl (MUL_WAIT=1 and MUL_WAIT=3 instances)
module tb_mult_share_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Stimulus, indexed [instance][port]
    logic [1:0] v  [2];
    logic [3:0] a  [2][2];
    logic [3:0] b  [2][2];
    logic [1:0] rr [2];

    // Observed outputs, indexed [instance]
    logic [1:0] rdy [2];
    logic [1:0] rv  [2];
    logic [7:0] p   [2];
    logic [3:0] ma  [2];
    logic [3:0] mb  [2];
    logic       bz  [2];

    mult_share_ctrl_if #(.WIDTH(4)) ifc0 ();
    mult_share_ctrl_if #(.WIDTH(4)) ifc1 ();

    mult_share_ctrl #(.WIDTH(4), .MUL_WAIT(1)) dut0 (.clk(clk), .rst(rst), .ms(ifc0.slave));
    mult_share_ctrl #(.WIDTH(4), .MUL_WAIT(3)) dut1 (.clk(clk), .rst(rst), .ms(ifc1.slave));

    assign ifc0.req0_valid = v[0][0];
    assign ifc0.req1_valid = v[0][1];
    assign ifc0.req0_a     = a[0][0];
    assign ifc0.req0_b     = b[0][0];
    assign ifc0.req1_a     = a[0][1];
    assign ifc0.req1_b     = b[0][1];
    assign ifc0.rsp0_ready = rr[0][0];
    assign ifc0.rsp1_ready = rr[0][1];
    assign ifc0.mul_y      = {4'b0, ifc0.mul_a} * {4'b0, ifc0.mul_b};
    assign rdy[0] = {ifc0.req1_ready, ifc0.req0_ready};
    assign rv[0]  = {ifc0.rsp1_valid, ifc0.rsp0_valid};
    assign p[0]   = ifc0.rsp_p;
    assign ma[0]  = ifc0.mul_a;
    assign mb[0]  = ifc0.mul_b;
    assign bz[0]  = ifc0.busy;

    assign ifc1.req0_valid = v[1][0];
    assign ifc1.req1_valid = v[1][1];
    assign ifc1.req0_a     = a[1][0];
    assign ifc1.req0_b     = b[1][0];
    assign ifc1.req1_a     = a[1][1];
    assign ifc1.req1_b     = b[1][1];
    assign ifc1.rsp0_ready = rr[1][0];
    assign ifc1.rsp1_ready = rr[1][1];
    assign ifc1.mul_y      = {4'b0, ifc1.mul_a} * {4'b0, ifc1.mul_b};
    assign rdy[1] = {ifc1.req1_ready, ifc1.req0_ready};
    assign rv[1]  = {ifc1.rsp1_valid, ifc1.rsp0_valid};
    assign p[1]   = ifc1.rsp_p;
    assign ma[1]  = ifc1.mul_a;
    assign mb[1]  = ifc1.mul_b;
    assign bz[1]  = ifc1.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for request, 1 settling (m_left edges to go), 2 holding product
    int         m_phase [2];
    int         m_left  [2];
    logic       m_gnt   [2];
    logic       m_last  [2];
    logic [7:0] m_prod  [2];
    logic [7:0] m_p     [2];
    logic [3:0] m_ma    [2];
    logic [3:0] m_mb    [2];

    function automatic int mw(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic win(input logic [1:0] vv, input logic last);
        if (vv == 2'b10) return 1'b1;
        if (vv == 2'b01) return 1'b0;
`ifdef MULT_SHARE_RR_EN
        return !last;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [1:0] exp_rdy(input int i);
        if (m_phase[i] != 0 || v[i] == 2'b00) return 2'b00;
        return win(v[i], m_last[i]) ? 2'b10 : 2'b01;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] <= 0;
                m_left[i]  <= 0;
                m_gnt[i]   <= 1'b0;
                m_last[i]  <= 1'b1;
                m_prod[i]  <= 8'd0;
                m_p[i]     <= 8'd0;
                m_ma[i]    <= 4'd0;
                m_mb[i]    <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_phase[i] == 0) begin
                    if (v[i] != 2'b00) begin
                        m_gnt[i]   <= win(v[i], m_last[i]);
                        m_last[i]  <= win(v[i], m_last[i]);
                        m_ma[i]    <= a[i][win(v[i], m_last[i])];
                        m_mb[i]    <= b[i][win(v[i], m_last[i])];
                        m_prod[i]  <= 8'(a[i][win(v[i], m_last[i])]) * 8'(b[i][win(v[i], m_last[i])]);
                        m_left[i]  <= mw(i);
                        m_phase[i] <= 1;
                    end
                end else if (m_phase[i] == 1) begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) begin
                        m_phase[i] <= 2;
                        m_p[i]     <= m_prod[i];
                    end
                end else begin
                    if (rr[i][m_gnt[i]]) m_phase[i] <= 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("i%0d req_ready", i), 32'(rdy[i]), 32'(exp_rdy(i)));
            chk($sformatf("i%0d rsp_valid", i), 32'(rv[i]),
                32'((m_phase[i] == 2) ? (m_gnt[i] ? 2'b10 : 2'b01) : 2'b00));
            chk($sformatf("i%0d rsp_p", i), 32'(p[i]), 32'(m_p[i]));
            chk($sformatf("i%0d busy", i), 32'(bz[i]), 32'(m_phase[i] != 0));
            chk($sformatf("i%0d mul_a", i), 32'(ma[i]), 32'(m_ma[i]));
            chk($sformatf("i%0d mul_b", i), 32'(mb[i]), 32'(m_mb[i]));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    logic [3:0] bb_a [4];
    logic [3:0] bb_b [4];
    logic [7:0] bb_p [4];

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v[i]  = 2'b00;
            rr[i] = 2'b00;
            for (int j = 0; j < 2; j++) begin
                a[i][j] = 4'd0;
                b[i][j] = 4'd0;
            end
        end
        bb_a = '{4'd1, 4'd9, 4'd15, 4'd0};
        bb_b = '{4'd1, 4'd9, 4'd14, 4'd12};
        bb_p = '{8'd1, 8'd81, 8'd210, 8'd0};
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("reset rsp_p", 32'(p[0]), 32'd0);
        chk("reset busy", 32'(bz[0]), 32'd0);
        chk("reset mul_a", 32'(ma[0]), 32'd0);
        chk("reset rsp_valid", 32'(rv[0]), 32'd0);

        // Single request 3x5, MUL_WAIT=1
        rr[0] = 2'b01;
        v[0] = 2'b01; a[0][0] = 4'd3; b[0][0] = 4'd5;
        #1 chk("single ready", 32'(rdy[0]), 32'b01);
        tick;
        v[0] = 2'b00;
        chk("single busy", 32'(bz[0]), 32'd1);
        chk("single no early rsp", 32'(rv[0]), 32'd0);
        tick;
        chk("single rsp_valid", 32'(rv[0]), 32'b01);
        chk("single product", 32'(p[0]), 32'd15);
        chk("single busy in resp", 32'(bz[0]), 32'd1);
        tick;
        chk("single back idle", 32'(bz[0]), 32'd0);

        // Backpressure: response held for 5 cycles, requester 1 waiting meanwhile
        rr[0] = 2'b00;
        v[0] = 2'b01;
        #1 chk("bp ready", 32'(rdy[0]), 32'b01);
        tick;
        v[0] = 2'b10; a[0][1] = 4'd1; b[0][1] = 4'd2;
        tick;
        for (int k = 0; k < 5; k++) begin
            chk("bp rsp_valid held", 32'(rv[0]), 32'b01);
            chk("bp product held", 32'(p[0]), 32'd15);
            chk("bp no accept", 32'(rdy[0]), 32'b00);
            tick;
        end
        rr[0] = 2'b01;
        tick;
        chk("bp pending served", 32'(rdy[0]), 32'b10);
        rr[0] = 2'b11;
        tick;
        v[0] = 2'b00;
        tick;
        chk("bp req1 product", 32'(p[0]), 32'd2);
        tick;

        // Simultaneous requests 2x7 and 4x4
        v[0] = 2'b11; a[0][0] = 4'd2; b[0][0] = 4'd7; a[0][1] = 4'd4; b[0][1] = 4'd4;
        #1 chk("tie first grant", 32'(rdy[0]), 32'b01);
        tick;
        v[0] = 2'b10;
        tick;
        chk("tie rsp0", 32'(rv[0]), 32'b01);
        chk("tie product 14", 32'(p[0]), 32'd14);
        tick;
        chk("tie req1 grant", 32'(rdy[0]), 32'b10);
        tick;
        v[0] = 2'b11;
        tick;
        chk("tie rsp1", 32'(rv[0]), 32'b10);
        chk("tie product 16", 32'(p[0]), 32'd16);
        tick;
        chk("tie repeat grant", 32'(rdy[0]), 32'b01);
        tick;
        v[0] = 2'b00;
        tick;
        tick;

        // Back-to-back on requester 0 with new operands each time
        rr[0] = 2'b01;
        for (int k = 0; k < 4; k++) begin
            v[0] = 2'b01; a[0][0] = bb_a[k]; b[0][0] = bb_b[k];
            #1 chk("b2b accept", 32'(rdy[0]), 32'b01);
            tick;
            if (k == 3) v[0] = 2'b00;
            chk("b2b busy", 32'(rv[0]), 32'd0);
            tick;
            chk("b2b rsp_valid", 32'(rv[0]), 32'b01);
            chk("b2b product", 32'(p[0]), 32'(bb_p[k]));
            tick;
        end

        // Maximum operands on requester 1, MUL_WAIT=3
        rr[1] = 2'b11;
        v[1] = 2'b10; a[1][1] = 4'd15; b[1][1] = 4'd15;
        #1 chk("max ready", 32'(rdy[1]), 32'b10);
        tick;
        v[1] = 2'b00;
        tick;
        tick;
        chk("max no early rsp", 32'(rv[1]), 32'd0);
        tick;
        chk("max rsp1 only", 32'(rv[1]), 32'b10);
        chk("max product 225", 32'(p[1]), 32'd225);
        tick;

        // Reset in the middle of a MUL_WAIT=3 transaction
        v[1] = 2'b01; a[1][0] = 4'd6; b[1][0] = 4'd7;
        tick;
        v[1] = 2'b00;
        tick;
        #2 rst = 1'b1;
        #1;
        chk("rst busy", 32'(bz[1]), 32'd0);
        chk("rst rsp_p", 32'(p[1]), 32'd0);
        chk("rst mul_a", 32'(ma[1]), 32'd0);
        chk("rst rsp_valid", 32'(rv[1]), 32'd0);
        tick;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("rst no late rsp", 32'(rv[1]), 32'd0);
            chk("rst stays idle", 32'(bz[1]), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
